button_debouncer: RTL

Debounces one already-synchronized push-button level and turns it into clean control events for the timer: a debounced level, single-cycle press and release pulses, and an auto-repeat pulse train while the button is held. It sits directly downstream of the two-flop synchronizer on each button input, and its pulses feed the timer's set and start/stop logic.

---
 rtl/button_debouncer_pkg.sv | 18 +
 rtl/button_debouncer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer and its users.
package button_debouncer_pkg;

  // Debouncer FSM states, visible to timer-level FSMs and benches.
  typedef enum logic [2:0] {
    RELEASED      = 3'd0,
    PRESS_CHECK   = 3'd1,
    PRESSED       = 3'd2,
    HELD          = 3'd3,
    RELEASE_CHECK = 3'd4
  } btn_state_t;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Debounces one synchronized button level into a clean level, press/release
// pulses and an auto-repeat pulse train with a long-press flag.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 20000,
  parameter int unsigned LONG_CYCLES   = 5000000,
  parameter int unsigned REPEAT_CYCLES = 2000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic LEVEL,
  output logic PRESS,
  output logic RELEASE,
  output logic REPEAT,
  output logic LONG
);

  localparam int unsigned DebW    = cnt_width(STABLE_CYCLES);
  localparam int unsigned HoldMax = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HoldW   = cnt_width(HoldMax);

  localparam logic [DebW-1:0]  DebMax  = DebW'(STABLE_CYCLES);
  localparam logic [HoldW-1:0] HoldSat = HoldW'(HoldMax);

  btn_state_t       state_q, state_d;
  logic [DebW-1:0]  deb_q, deb_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             level_q, level_d;
  logic             long_q, long_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  logic [DebW-1:0]  deb_inc;
  logic [HoldW-1:0] hold_inc;
  logic [31:0]      hold_target;
  logic             deb_done;
  logic             hold_done;

  // Saturating increments and threshold detection for both counters.
  always_comb begin
    deb_inc     = (deb_q == DebMax) ? deb_q : deb_q + DebW'(1);
    hold_inc    = (hold_q == HoldSat) ? hold_q : hold_q + HoldW'(1);
    hold_target = (state_q == HELD) ? REPEAT_CYCLES : LONG_CYCLES;
    // deb_q is 0 in RELEASED, so this also covers STABLE_CYCLES == 1 there.
    deb_done    = ((32'(deb_q) + 32'd1) == STABLE_CYCLES);
    hold_done   = ((32'(hold_q) + 32'd1) == hold_target);
  end

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    level_d   = level_q;
    long_d    = long_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      RELEASED, PRESS_CHECK: begin
        if (!IN) begin
          state_d = RELEASED;
          deb_d   = '0;
        end else if (deb_done) begin
          state_d = PRESSED;
          deb_d   = '0;
          hold_d  = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          state_d = PRESS_CHECK;
          deb_d   = deb_inc;
        end
      end

      PRESSED, HELD: begin
        if (!IN && (STABLE_CYCLES == 1)) begin
          // Single-sample debounce: release is accepted immediately.
          state_d   = RELEASED;
          deb_d     = '0;
          hold_d    = '0;
          level_d   = 1'b0;
          long_d    = 1'b0;
          release_d = 1'b1;
        end else begin
          // The first low sample still counts as a held cycle; freezing
          // starts with the RELEASE_CHECK cycles.
          if (hold_done) begin
            hold_d   = '0;
            repeat_d = 1'b1;
            long_d   = 1'b1;
            state_d  = HELD;
          end else begin
            hold_d = hold_inc;
          end
          if (!IN) begin
            state_d = RELEASE_CHECK;
            deb_d   = DebW'(1);
          end
        end
      end

      RELEASE_CHECK: begin
        if (IN) begin
          // long_q remembers whether the press had already gone long.
          state_d = long_q ? HELD : PRESSED;
          deb_d   = '0;
        end else if (deb_done) begin
          state_d   = RELEASED;
          deb_d     = '0;
          hold_d    = '0;
          level_d   = 1'b0;
          long_d    = 1'b0;
          release_d = 1'b1;
        end else begin
          deb_d = deb_inc;
        end
      end

      default: begin
        state_d = RELEASED;
        deb_d   = '0;
        hold_d  = '0;
        level_d = 1'b0;
        long_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RELEASED;
      deb_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      long_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      long_q    <= long_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign LEVEL   = level_q;
  assign PRESS   = press_q;
  assign RELEASE = release_q;
  assign REPEAT  = repeat_q;
  assign LONG    = long_q;

endmodule
